mpsoc_msi_ahb3_cmd_master: RTL and testbench

- AHB3-Lite master that converts a simple valid/ready command stream into pipelined single AHB transfers.
- Drives one master port of the msi AHB3 interconnect, i.e. one element of the interconnect's mst_* vectors.
- Used as the CPU/DMA stand-in and regression traffic source for peripheral (GPIO/UART bridges) and RAM slaves.
- Returns one response per command, in order, with read data and error status.

---
 rtl/mpsoc_msi_ahb3_cmd_master_if.sv | 54 +++++
 rtl/mpsoc_msi_ahb3_cmd_master.sv | 186 ++++++++++++++++++
 tb/tb_mpsoc_msi_ahb3_cmd_master.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_msi_ahb3_cmd_master_if.sv
// ---------------------------------------------------------------------------
// mpsoc_msi_ahb3_cmd_master_if
// Bundles the command/response stream and the AHB3-Lite master bus of the
// command master into one interface.
//   master modport : view of the command master (cmd in, rsp out, AHB out)
//   slave  modport : view of the environment (command source, response sink
//                    and AHB slave / interconnect port)
// Command stream : cmd_valid, cmd_ready, cmd_addr, cmd_write, cmd_size, cmd_wdata
// Response       : rsp_valid, rsp_rdata, rsp_err
// AHB3-Lite      : HSEL, HADDR, HWDATA, HRDATA, HWRITE, HSIZE, HBURST, HPROT,
//                  HTRANS, HMASTLOCK, HREADY, HRESP
// ---------------------------------------------------------------------------
interface mpsoc_msi_ahb3_cmd_master_if #(
    parameter int PLEN = 64,
    parameter int XLEN = 64
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [PLEN-1:0] cmd_addr;
    logic            cmd_write;
    logic [2:0]      cmd_size;
    logic [XLEN-1:0] cmd_wdata;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );
endinterface

// File: rtl/mpsoc_msi_ahb3_cmd_master.sv
// ---------------------------------------------------------------------------
// mpsoc_msi_ahb3_cmd_master
// AHB3-Lite master turning a valid/ready command stream into pipelined SINGLE
// transfers, one response per command, in command order.
// Ports:
//   HCLK     : clock, all state on posedge
//   HRESETn  : asynchronous active-low reset
//   bus      : mpsoc_msi_ahb3_cmd_master_if.master (command, response, AHB)
// Pipeline: address-phase registers feed data-phase registers whenever
// HREADY is high. A two-cycle ERROR response pulls back the command sitting in
// the address phase (HTRANS forced IDLE) and re-issues it once the errored
// data phase has finished.
// ---------------------------------------------------------------------------
module mpsoc_msi_ahb3_cmd_master #(
    parameter int         PLEN      = 64,
    parameter int         XLEN      = 64,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic HCLK,
    input  logic HRESETn,
    mpsoc_msi_ahb3_cmd_master_if.master bus
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_ERROR  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // address phase
    logic            r_nonseq;
    logic [PLEN-1:0] r_haddr;
    logic            r_hwrite;
    logic [2:0]      r_hsize;
    logic [XLEN-1:0] r_awdata;    // write data travelling with the address phase

    // data phase
    logic            r_dpv;
    logic            r_dp_write;
    logic [XLEN-1:0] r_hwdata;

    // command pulled back from the address phase during an error response
    logic            r_rp_valid;
    logic [PLEN-1:0] r_rp_addr;
    logic            r_rp_write;
    logic [2:0]      r_rp_size;
    logic [XLEN-1:0] r_rp_wdata;

    // response
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [XLEN-1:0] r_rsp_rdata;

    logic            w_cmd_ready;
    logic            w_advance;     // normal pipeline step
    logic            w_err_start;   // first cycle of a two-cycle ERROR
    logic            w_err_end;     // second cycle of ERROR, data phase ends

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_advance   = 1'b0;
        w_err_start = 1'b0;
        w_err_end   = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                w_cmd_ready = bus.HREADY;
                // HRESP without an active data phase is not ours and is ignored
                if (r_dpv && bus.HRESP && !bus.HREADY) begin
                    w_err_start = 1'b1;
                    w_state_nxt = ST_ERROR;
                end else if (bus.HREADY) begin
                    w_advance   = 1'b1;
                end else begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            ST_ERROR: begin
                if (bus.HREADY) begin
                    w_err_end   = 1'b1;
                    w_state_nxt = ST_NORMAL;
                end else begin
                    w_state_nxt = ST_ERROR;
                end
            end
            default: begin
                w_state_nxt = ST_NORMAL;
            end
        endcase
    end

    // Address, data and replay registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_nonseq   <= 1'b0;
            r_haddr    <= {PLEN{1'b0}};
            r_hwrite   <= 1'b0;
            r_hsize    <= 3'b000;
            r_awdata   <= {XLEN{1'b0}};
            r_dpv      <= 1'b0;
            r_dp_write <= 1'b0;
            r_hwdata   <= {XLEN{1'b0}};
            r_rp_valid <= 1'b0;
            r_rp_addr  <= {PLEN{1'b0}};
            r_rp_write <= 1'b0;
            r_rp_size  <= 3'b000;
            r_rp_wdata <= {XLEN{1'b0}};
        end else if (w_advance) begin
            r_nonseq   <= bus.cmd_valid;
            if (bus.cmd_valid) begin
                r_haddr  <= bus.cmd_addr;
                r_hwrite <= bus.cmd_write;
                r_hsize  <= bus.cmd_size;
                r_awdata <= bus.cmd_wdata;
            end
            r_dpv      <= r_nonseq;
            r_dp_write <= r_hwrite;
            r_hwdata   <= r_awdata;
        end else if (w_err_start) begin
            // AHB requires IDLE in the second error cycle; park the pending command
            r_rp_valid <= r_nonseq;
            if (r_nonseq) begin
                r_rp_addr  <= r_haddr;
                r_rp_write <= r_hwrite;
                r_rp_size  <= r_hsize;
                r_rp_wdata <= r_awdata;
            end
            r_nonseq   <= 1'b0;
        end else if (w_err_end) begin
            // errored data phase finishes; address phase was IDLE so none follows
            r_dpv      <= 1'b0;
            r_rp_valid <= 1'b0;
            r_nonseq   <= r_rp_valid;
            if (r_rp_valid) begin
                r_haddr  <= r_rp_addr;
                r_hwrite <= r_rp_write;
                r_hsize  <= r_rp_size;
                r_awdata <= r_rp_wdata;
            end
        end else begin
            r_nonseq <= r_nonseq;
        end
    end

    // Response pulse whenever a data phase completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= {XLEN{1'b0}};
        end else if (r_dpv && bus.HREADY) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus.HRESP;
            r_rsp_rdata <= r_dp_write ? {XLEN{1'b0}} : bus.HRDATA;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.HTRANS    = {r_nonseq, 1'b0};
    assign bus.HSEL      = r_nonseq;
    assign bus.HADDR     = r_haddr;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HSIZE     = r_hsize;
    assign bus.HWDATA    = r_hwdata;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_mpsoc_msi_ahb3_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_mpsoc_msi_ahb3_cmd_master
// Self-checking bench: a behavioural AHB RAM slave (wait states and two-cycle
// ERROR responses on selected addresses), a table of directed commands,
// hand-written timing sequences and a randomized run scored against a
// memory-level model of what every response must contain.
// ---------------------------------------------------------------------------
module tb_mpsoc_msi_ahb3_cmd_master;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b1;
    always #5 HCLK = ~HCLK;

    mpsoc_msi_ahb3_cmd_master_if bus ();

    mpsoc_msi_ahb3_cmd_master dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    typedef struct {
        int          cyc;
        logic [63:0] d;
        logic        e;
    } rsp_t;

    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [2:0]  sz;
        logic [63:0] wd;
        logic [63:0] er;
        logic        ee;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    rsp_t        rsp_log[$];
    rsp_t        mon_r;
    exp_t        exp_log[$];
    int          n_chk = 0;
    logic [63:0] ref_mem [64];
    logic [63:0] mem     [64];

    // slave configuration, written by the stimulus only
    logic        err_en    = 1'b0;
    logic [63:0] err_addr  = 64'h0;
    logic        rnd_err   = 1'b0;
    logic        rnd_wait  = 1'b0;
    logic [63:0] wait_addr = 64'hFFFF_FFFF;
    int          wait_n    = 0;

    // slave data-phase state
    logic        s_act;
    logic [63:0] s_addr;
    logic        s_write;
    logic        s_err;
    logic        s_errph;
    int          s_wait;

    function automatic logic [63:0] init_word(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 3)};
    endfunction

    function automatic logic slave_err(input logic [63:0] a);
        return (err_en && (a == err_addr)) || (rnd_err && ((a[8:3] % 6'd5) == 6'd0));
    endfunction

    always @(posedge HCLK) cyc <= cyc + 1;

    // response monitor
    always @(negedge HCLK) begin
        if (HRESETn && bus.rsp_valid) begin
            mon_r.cyc = cyc;
            mon_r.d   = bus.rsp_rdata;
            mon_r.e   = bus.rsp_err;
            rsp_log.push_back(mon_r);
        end
    end

    // AHB slave: bus outputs from the current data-phase state
    always_comb begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 64'h0;
        if (s_act) begin
            if (s_wait != 0) begin
                bus.HREADY = 1'b0;
            end else if (s_err) begin
                bus.HRESP  = 1'b1;
                bus.HREADY = s_errph;
            end else begin
                bus.HRDATA = mem[s_addr[8:3]];
            end
        end
    end

    // AHB slave: data-phase progress and address-phase capture
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_act   <= 1'b0;
            s_addr  <= 64'h0;
            s_write <= 1'b0;
            s_err   <= 1'b0;
            s_errph <= 1'b0;
            s_wait  <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else begin
            if (s_act) begin
                if (s_wait != 0) begin
                    s_wait <= s_wait - 1;
                end else if (s_err && !s_errph) begin
                    s_errph <= 1'b1;
                end else begin
                    s_act <= 1'b0;
                    if (s_write && !s_err) mem[s_addr[8:3]] <= bus.HWDATA;
                end
            end
            if (bus.HREADY && bus.HTRANS[1]) begin
                s_act   <= 1'b1;
                s_addr  <= bus.HADDR;
                s_write <= bus.HWRITE;
                s_err   <= slave_err(bus.HADDR);
                s_errph <= 1'b0;
                s_wait  <= rnd_wait ? int'($urandom_range(0, 2)) :
                           ((bus.HADDR == wait_addr) ? wait_n : 0);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_htrans"},    64'(bus.HTRANS),    64'h0);
        check({tag, "_hsel"},      64'(bus.HSEL),      64'h0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'h0);
        check({tag, "_hburst"},    64'(bus.HBURST),    64'h0);
        check({tag, "_hprot"},     64'(bus.HPROT),     64'h3);
        check({tag, "_hmastlock"}, 64'(bus.HMASTLOCK), 64'h0);
    endtask

    // Present one command and wait (bounded) until it is accepted
    task automatic issue(input logic w, input logic [63:0] a, input logic [2:0] sz,
                         input logic [63:0] wd, input logic [63:0] er, input logic ee,
                         output int acc, output int refused);
        logic rdy;
        exp_t x;
        @(negedge HCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = sz;
        bus.cmd_wdata = wd;
        acc     = -1;
        refused = 0;
        for (int k = 0; k < 64 && acc < 0; k++) begin
            #4;
            rdy = bus.cmd_ready;
            @(posedge HCLK);
            #1;
            if (rdy) begin
                acc = cyc;
                check("acc_htrans", 64'(bus.HTRANS), 64'h2);
                check("acc_haddr",  bus.HADDR,       a);
                check("acc_hwrite", 64'(bus.HWRITE), 64'(w));
                check("acc_hsize",  64'(bus.HSIZE),  64'(sz));
            end else begin
                refused++;
                @(negedge HCLK);
            end
        end
        if (acc < 0) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept_timeout: got no cmd_ready expected acceptance of addr %h", a);
        end
        x.d = er;
        x.e = ee;
        exp_log.push_back(x);
        if (w && !ee) ref_mem[a[8:3]] = wd;
    endtask

    task automatic go_idle();
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for all expected responses, then score them in order
    task automatic drain();
        for (int k = 0; k < 300 && rsp_log.size() < exp_log.size(); k++) @(negedge HCLK);
        repeat (4) @(negedge HCLK);
        check("rsp_count", 64'(rsp_log.size()), 64'(exp_log.size()));
        for (int k = n_chk; k < exp_log.size() && k < rsp_log.size(); k++) begin
            check("rsp_rdata", rsp_log[k].d,      exp_log[k].d);
            check("rsp_err",   64'(rsp_log[k].e), 64'(exp_log[k].e));
        end
        n_chk = exp_log.size();
    endtask

    vec_t tbl [10];
    int   acc [10];
    int   a0, a1, a2, rf, base;
    logic        rw, re;
    logic [63:0] ra, rwd, rer;
    logic [2:0]  rsz;

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b0, 64'(i * 8), 3'd3, 64'h0, init_word(i), 1'b0};
        end
        tbl[8] = '{1'b1, 64'h180, 3'd2, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        tbl[9] = '{1'b0, 64'h180, 3'd3, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 64'h0;
        bus.cmd_size  = 3'd0;
        bus.cmd_wdata = 64'h0;

        // reset values, idle bus
        #1 HRESETn = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            chk_idle("rst");
        end
        check("rst_haddr",  bus.HADDR,          64'h0);
        check("rst_hwdata", bus.HWDATA,         64'h0);
        check("rst_rdata",  bus.rsp_rdata,      64'h0);
        check("rst_err",    64'(bus.rsp_err),   64'h0);
        check("rst_hwrite", 64'(bus.HWRITE),    64'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (3) begin
            @(negedge HCLK);
            chk_idle("idle");
        end

        // write then read back-to-back, zero wait
        base = exp_log.size();
        issue(1'b1, 64'h100, 3'd3, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0, a0, rf);
        issue(1'b0, 64'h100, 3'd3, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0, a1, rf);
        check("wr_dphase_hwdata", bus.HWDATA, 64'hDEAD_BEEF_0123_4567);
        check("wr_rd_b2b", 64'(a1), 64'(a0 + 1));
        go_idle();
        drain();
        check("wr_rsp_latency", 64'(rsp_log[base].cyc),     64'(a0 + 2));
        check("rd_rsp_latency", 64'(rsp_log[base + 1].cyc), 64'(a0 + 3));

        // directed table: 8 sequential reads plus a write/read pair
        base = exp_log.size();
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, tbl[i].er, tbl[i].ee, acc[i], rf);
            if (i > 0) check("tbl_b2b", 64'(acc[i]), 64'(acc[i - 1] + 1));
        end
        go_idle();
        drain();
        check("tbl_first_lat", 64'(rsp_log[base].cyc),     64'(acc[0] + 2));
        check("tbl_last_lat",  64'(rsp_log[base + 9].cyc), 64'(acc[9] + 2));

        // three wait states on a read of 0x40 with further commands queued
        wait_addr = 64'h40;
        wait_n    = 3;
        base = exp_log.size();
        issue(1'b0, 64'h40, 3'd3, 64'h0, init_word(8), 1'b0, a0, rf);
        issue(1'b0, 64'h48, 3'd3, 64'h0, init_word(9), 1'b0, a1, rf);
        check("wait_haddr_hold",  bus.HADDR,          64'h48);
        check("wait_htrans_hold", 64'(bus.HTRANS),    64'h2);
        check("wait_cmd_ready",   64'(bus.cmd_ready), 64'h0);
        issue(1'b0, 64'h50, 3'd3, 64'h0, init_word(10), 1'b0, a2, rf);
        check("wait_refused", 64'(rf), 64'd3);
        check("wait_accept",  64'(a2), 64'(a1 + 4));
        go_idle();
        wait_addr = 64'hFFFF_FFFF;
        wait_n    = 0;
        drain();
        check("wait_rsp_latency", 64'(rsp_log[base].cyc), 64'(a0 + 5));

        // error on write 0x8 while write 0x10 sits in the address phase
        err_en   = 1'b1;
        err_addr = 64'h8;
        base = exp_log.size();
        issue(1'b1, 64'h8,  3'd3, 64'h1111_2222_3333_4444, 64'h0, 1'b1, a0, rf);
        issue(1'b1, 64'h10, 3'd3, 64'h5555_6666_7777_8888, 64'h0, 1'b0, a1, rf);
        go_idle();
        @(negedge HCLK);
        check("err2_htrans",    64'(bus.HTRANS),    64'h0);
        check("err2_cmd_ready", 64'(bus.cmd_ready), 64'h0);
        @(negedge HCLK);
        check("replay_htrans", 64'(bus.HTRANS),    64'h2);
        check("replay_haddr",  bus.HADDR,          64'h10);
        check("err_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("err_rsp_err",   64'(bus.rsp_err),   64'h1);
        drain();
        check("err_rsp_pair", 64'(rsp_log.size() - base), 64'd2);
        check("replay_rsp_latency", 64'(rsp_log[base + 1].cyc), 64'(a0 + 5));
        err_en = 1'b0;

        // read back the replayed write and the untouched errored word
        issue(1'b0, 64'h10, 3'd3, 64'h0, 64'h5555_6666_7777_8888, 1'b0, a0, rf);
        issue(1'b0, 64'h8,  3'd3, 64'h0, init_word(1), 1'b0, a1, rf);
        go_idle();
        drain();

        // reset asserted during the data phase of a read
        issue(1'b0, 64'h20, 3'd3, 64'h0, ref_mem[4], 1'b0, a0, rf);
        go_idle();
        @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        check("mid_rst_htrans", 64'(bus.HTRANS),    64'h0);
        check("mid_rst_hsel",   64'(bus.HSEL),      64'h0);
        check("mid_rst_haddr",  bus.HADDR,          64'h0);
        check("mid_rst_rsp",    64'(bus.rsp_valid), 64'h0);
        void'(exp_log.pop_back());
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drain();

        // randomized traffic with random waits and address-selected errors
        rnd_wait = 1'b1;
        rnd_err  = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                go_idle();
                repeat ($urandom_range(0, 2)) @(negedge HCLK);
            end
            rw  = 1'($urandom_range(0, 1));
            ra  = {55'd0, 6'($urandom_range(0, 63)), 3'd0};
            rsz = 3'($urandom_range(0, 3));
            rwd = {$urandom, $urandom};
            re  = slave_err(ra);
            rer = (rw || re) ? 64'h0 : ref_mem[ra[8:3]];
            issue(rw, ra, rsz, rwd, rer, re, a0, rf);
        end
        go_idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
